// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: two-source (ALU/load) writeback arbiter with 1-entry slots and a registered write stage.
// Optional REGFILE_FORWARD_EN adds youngest-pending-value forwarding on FwdRS/FwdRT.
module regfile_write_arbiter #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4,
    parameter int NREG   = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              AValid,
    input  logic [ADDR_W-1:0] ARd,
    input  logic [DATA_W-1:0] AData,
    output logic              AReady,
    input  logic              MValid,
    input  logic [ADDR_W-1:0] MRd,
    input  logic [DATA_W-1:0] MData,
    output logic              MReady,
    output logic [ADDR_W-1:0] RD,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    output logic [NREG-1:0]   PendingMask,
    input  logic [ADDR_W-1:0] RS,
    input  logic [ADDR_W-1:0] RT,
    input  logic [DATA_W-1:0] RFReadRS,
    input  logic [DATA_W-1:0] RFReadRT,
    output logic [DATA_W-1:0] FwdRS,
    output logic [DATA_W-1:0] FwdRT
);
    logic              a_full_q, a_full_d, m_full_q, m_full_d;
    logic [ADDR_W-1:0] a_rd_q, a_rd_d, m_rd_q, m_rd_d, rd_q, rd_d;
    logic [DATA_W-1:0] a_data_q, a_data_d, m_data_q, m_data_d, wdata_q, wdata_d;
    logic              m_older_q, m_older_d, last_m_q, last_m_d, reg_write_q, reg_write_d;
    logic              grant_a, grant_m, a_acc, m_acc;

    // Same destination must retire in arrival order; otherwise alternate.
    always_comb begin
        grant_a     = a_full_q && (!m_full_q || ((a_rd_q == m_rd_q) ? !m_older_q : last_m_q));
        grant_m     = m_full_q && !grant_a;
        AReady      = !a_full_q || grant_a;
        MReady      = !m_full_q || grant_m;
        a_acc       = AValid && AReady;
        m_acc       = MValid && MReady;
        a_full_d    = a_acc || (a_full_q && !grant_a);
        m_full_d    = m_acc || (m_full_q && !grant_m);
        a_rd_d      = a_acc ? ARd : a_rd_q;
        a_data_d    = a_acc ? AData : a_data_q;
        m_rd_d      = m_acc ? MRd : m_rd_q;
        m_data_d    = m_acc ? MData : m_data_q;
        m_older_d   = a_acc ? 1'b1 : (m_acc ? 1'b0 : m_older_q);
        last_m_d    = grant_m ? 1'b1 : (grant_a ? 1'b0 : last_m_q);
        reg_write_d = grant_a || grant_m;
        rd_d        = grant_a ? a_rd_q : (grant_m ? m_rd_q : rd_q);
        wdata_d     = grant_a ? a_data_q : (grant_m ? m_data_q : wdata_q);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            a_full_q    <= 1'b0;
            m_full_q    <= 1'b0;
            a_rd_q      <= '0;
            a_data_q    <= '0;
            m_rd_q      <= '0;
            m_data_q    <= '0;
            m_older_q   <= 1'b0;
            last_m_q    <= 1'b1;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wdata_q     <= '0;
        end else begin
            a_full_q    <= a_full_d;
            m_full_q    <= m_full_d;
            a_rd_q      <= a_rd_d;
            a_data_q    <= a_data_d;
            m_rd_q      <= m_rd_d;
            m_data_q    <= m_data_d;
            m_older_q   <= m_older_d;
            last_m_q    <= last_m_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
        end
    end

    assign RegWrite    = reg_write_q;
    assign RD          = rd_q;
    assign WriteData   = wdata_q;
    assign PendingMask = (a_full_q ? (NREG'(1) << a_rd_q) : '0)
                       | (m_full_q ? (NREG'(1) << m_rd_q) : '0)
                       | (reg_write_q ? (NREG'(1) << rd_q) : '0);

`ifdef REGFILE_FORWARD_EN
    function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] idx, input logic [DATA_W-1:0] rf);
        logic a_hit, m_hit;
        a_hit = a_full_q && (a_rd_q == idx);
        m_hit = m_full_q && (m_rd_q == idx);
        return (a_hit && m_hit) ? (m_older_q ? a_data_q : m_data_q) :
               a_hit ? a_data_q :
               m_hit ? m_data_q :
               (reg_write_q && rd_q == idx) ? wdata_q : rf;
    endfunction
    assign FwdRS = fwd(RS, RFReadRS);
    assign FwdRT = fwd(RT, RFReadRT);
`else
    logic unused_idx;
    assign unused_idx = ^{RS, RT};
    assign FwdRS      = RFReadRS;
    assign FwdRT      = RFReadRT;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of arbitration, latency, reset and forwarding.
module tb_regfile_write_arbiter;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        AValid = 1'b0, MValid = 1'b0;
    logic [3:0]  ARd = '0, MRd = '0, RS = '0, RT = '0;
    logic [23:0] AData = '0, MData = '0;
    logic        AReady, MReady, RegWrite;
    logic [3:0]  RD;
    logic [23:0] WriteData, RFReadRS, RFReadRT, FwdRS, FwdRT;
    logic [15:0] PendingMask;
    logic [23:0] rf [16];
    logic        rf_clr = 1'b1;
    int          n_cmp = 0, n_err = 0;

    regfile_write_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .AValid(AValid), .ARd(ARd), .AData(AData), .AReady(AReady),
        .MValid(MValid), .MRd(MRd), .MData(MData), .MReady(MReady),
        .RD(RD), .WriteData(WriteData), .RegWrite(RegWrite), .PendingMask(PendingMask),
        .RS(RS), .RT(RT), .RFReadRS(RFReadRS), .RFReadRT(RFReadRT),
        .FwdRS(FwdRS), .FwdRT(FwdRT)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (RegWrite) begin
            rf[RD] <= WriteData;
        end
    end

    assign RFReadRS = rf[RS];
    assign RFReadRT = rf[RT];

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        step();
        step();
        rf_clr = 1'b0;
        Reset  = 1'b0;
        chk("rst_regwrite", 32'(RegWrite), 0);
        chk("rst_rd", 32'(RD), 0);
        chk("rst_wdata", 32'(WriteData), 0);
        chk("rst_pending", 32'(PendingMask), 0);
        chk("rst_aready", 32'(AReady), 1);
        chk("rst_mready", 32'(MReady), 1);

        // reset while A slot full and a write in flight to r8
        AValid = 1'b1; ARd = 4'd8; AData = 24'h999;
        step();
        AData = 24'h998;
        step();
        chk("mid_regwrite", 32'(RegWrite), 1);
        chk("mid_pending", 32'(PendingMask), 32'h100);
        AValid = 1'b0;
        Reset  = 1'b1;
        #1;
        chk("arst_regwrite", 32'(RegWrite), 0);
        chk("arst_pending", 32'(PendingMask), 0);
        chk("arst_aready", 32'(AReady), 1);
        chk("arst_mready", 32'(MReady), 1);
        step();
        Reset = 1'b0;
        step();
        RS = 4'd8;
        #1;
        chk("arst_r8_kept", 32'(FwdRS), 0);

        // simultaneous, different RD: A first after reset
        AValid = 1'b1; ARd = 4'd3; AData = 24'h111;
        MValid = 1'b1; MRd = 4'd5; MData = 24'h222;
        step();
        AValid = 1'b0; MValid = 1'b0;
        chk("rr_mready_low", 32'(MReady), 0);
        chk("rr_aready", 32'(AReady), 1);
        chk("rr_pending", 32'(PendingMask), 32'h28);
        step();
        chk("rr_w1_en", 32'(RegWrite), 1);
        chk("rr_w1_rd", 32'(RD), 3);
        chk("rr_w1_data", 32'(WriteData), 32'h111);
        chk("rr_mready_back", 32'(MReady), 1);
        step();
        chk("rr_w2_rd", 32'(RD), 5);
        chk("rr_w2_data", 32'(WriteData), 32'h222);
        step();
        chk("rr_idle_en", 32'(RegWrite), 0);
        chk("rr_idle_pending", 32'(PendingMask), 0);

        // same RD: M older, A retires last
        AValid = 1'b1; ARd = 4'd7; AData = 24'hAAA;
        MValid = 1'b1; MRd = 4'd7; MData = 24'hBBB;
        step();
        AValid = 1'b0; MValid = 1'b0;
        chk("same_pending0", 32'(PendingMask), 32'h80);
        step();
        chk("same_w1_rd", 32'(RD), 7);
        chk("same_w1_data", 32'(WriteData), 32'hBBB);
        chk("same_pending1", 32'(PendingMask), 32'h80);
        step();
        chk("same_w2_data", 32'(WriteData), 32'hAAA);
        chk("same_pending2", 32'(PendingMask), 32'h80);
        step();
        chk("same_pending3", 32'(PendingMask), 0);
        RS = 4'd7;
        #1;
        chk("same_r7_final", 32'(FwdRS), 32'hAAA);

        // A only, back-to-back
        AValid = 1'b1; ARd = 4'd8; AData = 24'd4;
        step();
        ARd = 4'd9; AData = 24'd2;
        step();
        AValid = 1'b0;
        chk("aonly_w1_en", 32'(RegWrite), 1);
        chk("aonly_w1_rd", 32'(RD), 8);
        chk("aonly_w1_data", 32'(WriteData), 4);
        step();
        chk("aonly_w2_en", 32'(RegWrite), 1);
        chk("aonly_w2_rd", 32'(RD), 9);
        chk("aonly_w2_data", 32'(WriteData), 2);
        step();
        chk("aonly_off", 32'(RegWrite), 0);
        chk("aonly_rd_hold", 32'(RD), 9);
        RS = 4'd8; RT = 4'd9;
        #1;
        chk("aonly_rs", 32'(FwdRS), 4);
        chk("aonly_rt", 32'(FwdRT), 2);

        // M only
        MValid = 1'b1; MRd = 4'd1; MData = 24'h321;
        step();
        MValid = 1'b0;
        chk("monly_mready", 32'(MReady), 1);
        step();
        chk("monly_rd", 32'(RD), 1);
        chk("monly_data", 32'(WriteData), 32'h321);
        step();

        // sustained A stream
        for (int i = 0; i < 6; i++) begin
            AValid = 1'b1; ARd = 4'(10 + i); AData = 24'(32'h100 + i);
            step();
            chk("stream_aready", 32'(AReady), 1);
            if (i > 0) begin
                chk("stream_en", 32'(RegWrite), 1);
                chk("stream_data", 32'(WriteData), 32'h100 + 32'(i - 1));
            end
        end
        AValid = 1'b0;
        step();
        chk("stream_last", 32'(WriteData), 32'h105);
        step();
        chk("stream_done", 32'(RegWrite), 0);

        // forwarding from the A slot
        AValid = 1'b1; ARd = 4'd4; AData = 24'h00ABCD;
        step();
        AValid = 1'b0;
        RS = 4'd4;
        #1;
`ifdef REGFILE_FORWARD_EN
        chk("fwd_rs", 32'(FwdRS), 32'h00ABCD);
`else
        chk("fwd_rs", 32'(FwdRS), 0);
`endif
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
